// File: rtl/myriadrf_pkg.sv
// Shared constants and helpers for the MyriadRF LMS6002D TX stream interface.
package myriadrf_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_I    = 2'd1;
    localparam logic [1:0] ST_Q    = 2'd2;

    localparam int DEFAULT_DW = 12;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/myriadrf_sync_fifo.sv
// Single-clock show-ahead FIFO with extra-bit pointers; level = wr_ptr - rd_ptr.
module myriadrf_sync_fifo #(
    parameter int DW = 24,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

    logic [DW-1:0] mem_r [0:(1<<AW)-1];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic          do_wr_s;
    logic          do_rd_s;

    assign level   = wr_ptr_r - rd_ptr_r;
    assign full    = (level == DEPTH);
    assign empty   = (level == {(AW+1){1'b0}});
    assign do_wr_s = wr_en & ~full;
    assign do_rd_s = rd_en & ~empty;
    assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; writes into a full FIFO and reads from an empty one are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_wr_s) wr_ptr_r <= wr_ptr_r + ONE;
            if (do_rd_s) rd_ptr_r <= rd_ptr_r + ONE;
        end
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr_s) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/myriadrf_tx_stream.sv
// LMS6002D TX interface: buffers {I,Q} pairs and serialises them I-then-Q onto txd with txiqsel.
module myriadrf_tx_stream
    import myriadrf_pkg::*;
#(
    parameter int   DW            = DEFAULT_DW,
    parameter int   FIFO_AW       = 4,
    parameter logic IQSEL_I       = 1'b0,
    parameter logic UNDERRUN_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              iq_swap,
    input  logic [2*DW-1:0]   s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic [DW-1:0]     txd,
    output logic              txiqsel,
    output logic [FIFO_AW:0]  fifo_level,
    output logic              underrun,
    input  logic              underrun_clr,
    output logic [15:0]       underrun_cnt
);

    logic [1:0]      state_r;
    logic [DW-1:0]   txd_r;
    logic            txiqsel_r;
    logic [DW-1:0]   second_r;
    logic [2*DW-1:0] last_r;
    logic            underrun_r;
    logic [15:0]     underrun_cnt_r;

    logic [2*DW-1:0] fifo_data_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            pop_s;
    logic            under_s;
    logic [2*DW-1:0] pair_s;
    logic [DW-1:0]   first_s;
    logic [DW-1:0]   second_s;

    myriadrf_sync_fifo #(.DW(2*DW), .AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (s_valid_i),
        .wr_data (s_data_i),
        .rd_en   (pop_s),
        .rd_data (fifo_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level)
    );

    assign s_ready_o    = ~fifo_full_s;
    assign pop_s        = (state_r == ST_I);
    assign under_s      = (state_r == ST_I) & fifo_empty_s;
    assign txd          = txd_r;
    assign txiqsel      = txiqsel_r;
    assign underrun     = underrun_r;
    assign underrun_cnt = underrun_cnt_r;

    // Select the pair for the next S_I slot and order its words by iq_swap.
    always_comb begin
        pair_s = last_r;
        if (!fifo_empty_s) begin
            pair_s = fifo_data_s;
        end else if (UNDERRUN_ZERO) begin
            pair_s = {(2*DW){1'b0}};
        end else begin
            pair_s = last_r;
        end
        if (iq_swap) begin
            first_s  = pair_s[DW-1:0];
            second_s = pair_s[2*DW-1:DW];
        end else begin
            first_s  = pair_s[2*DW-1:DW];
            second_s = pair_s[DW-1:0];
        end
    end

    // Framing FSM: state names the slot driven at the next edge; pairs are never split.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            txd_r     <= {DW{1'b0}};
            txiqsel_r <= IQSEL_I;
            second_r  <= {DW{1'b0}};
            last_r    <= {(2*DW){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    txd_r     <= {DW{1'b0}};
                    txiqsel_r <= IQSEL_I;
                    state_r   <= en ? ST_I : ST_IDLE;
                end
                ST_I: begin
                    txd_r     <= first_s;
                    txiqsel_r <= IQSEL_I;
                    second_r  <= second_s;
                    last_r    <= pair_s;
                    state_r   <= ST_Q;
                end
                ST_Q: begin
                    txd_r     <= second_r;
                    txiqsel_r <= ~IQSEL_I;
                    state_r   <= en ? ST_I : ST_IDLE;
                end
                default: begin
                    txd_r     <= {DW{1'b0}};
                    txiqsel_r <= IQSEL_I;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky underrun flag and saturating counter; a clear wins over a same-cycle event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            underrun_r     <= 1'b0;
            underrun_cnt_r <= 16'd0;
        end else if (underrun_clr) begin
            underrun_r     <= 1'b0;
            underrun_cnt_r <= 16'd0;
        end else if (under_s) begin
            underrun_r     <= 1'b1;
            underrun_cnt_r <= sat_inc16(underrun_cnt_r);
        end else begin
            underrun_r     <= underrun_r;
            underrun_cnt_r <= underrun_cnt_r;
        end
    end

endmodule

// File: tb/tb_myriadrf_tx_stream.sv
// Directed bench: two DUTs (zero-fill and repeat underrun modes) checked every cycle against a queue model.
module tb_myriadrf_tx_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        iq_swap = 1'b0;
    logic [23:0] s_data_i = 24'h0;
    logic        s_valid_i = 1'b0;
    logic        underrun_clr = 1'b0;

    logic        rdy_z, sel_z, und_z, rdy_r, sel_r, und_r;
    logic [11:0] txd_z, txd_r;
    logic [4:0]  lvl_z, lvl_r;
    logic [15:0] cnt_z, cnt_r;

    int vec_cnt = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    myriadrf_tx_stream #(.DW(12), .FIFO_AW(4), .IQSEL_I(1'b0), .UNDERRUN_ZERO(1'b1)) dut_z (
        .clk(clk), .rst_n(rst_n), .en(en), .iq_swap(iq_swap), .s_data_i(s_data_i),
        .s_valid_i(s_valid_i), .s_ready_o(rdy_z), .txd(txd_z), .txiqsel(sel_z),
        .fifo_level(lvl_z), .underrun(und_z), .underrun_clr(underrun_clr), .underrun_cnt(cnt_z)
    );

    myriadrf_tx_stream #(.DW(12), .FIFO_AW(4), .IQSEL_I(1'b0), .UNDERRUN_ZERO(1'b0)) dut_r (
        .clk(clk), .rst_n(rst_n), .en(en), .iq_swap(iq_swap), .s_data_i(s_data_i),
        .s_valid_i(s_valid_i), .s_ready_o(rdy_r), .txd(txd_r), .txiqsel(sel_r),
        .fifo_level(lvl_r), .underrun(und_r), .underrun_clr(underrun_clr), .underrun_cnt(cnt_r)
    );

    // Model: index 0 = zero-fill mode, 1 = repeat-last mode. phase: 0 idle, 1 I slot due, 2 Q slot due.
    logic [23:0] m_q [$];
    int          m_phase = 0;
    logic [11:0] m_txd [2];
    logic [11:0] m_sec [2];
    logic [23:0] m_last [2];
    logic        m_sel = 1'b0;
    logic        m_und = 1'b0;
    logic [15:0] m_cnt = 16'h0;
    bit          m_ok = 1'b0;

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [23:0] popped;
        logic [23:0] p;
        logic        push;
        logic        starved;
        logic        ev;
        popped = 24'h0;
        ev = 1'b0;
        if (!rst_n) begin
            m_q.delete();
            m_phase = 0;
            m_sel = 1'b0;
            m_und = 1'b0;
            m_cnt = 16'h0;
            for (int k = 0; k < 2; k++) begin
                m_txd[k] = 12'h0;
                m_sec[k] = 12'h0;
                m_last[k] = 24'h0;
            end
            m_ok = 1'b1;
        end else begin
            push = s_valid_i && (m_q.size() < 16);
            starved = (m_q.size() == 0);
            if (m_phase == 0) begin
                for (int k = 0; k < 2; k++) m_txd[k] = 12'h0;
                m_sel = 1'b0;
                m_phase = en ? 1 : 0;
            end else if (m_phase == 1) begin
                if (!starved) popped = m_q.pop_front();
                for (int k = 0; k < 2; k++) begin
                    p = !starved ? popped : ((k == 0) ? 24'h0 : m_last[k]);
                    m_last[k] = p;
                    m_txd[k] = iq_swap ? p[11:0] : p[23:12];
                    m_sec[k] = iq_swap ? p[23:12] : p[11:0];
                end
                m_sel = 1'b0;
                m_phase = 2;
                ev = starved;
            end else begin
                for (int k = 0; k < 2; k++) m_txd[k] = m_sec[k];
                m_sel = 1'b1;
                m_phase = en ? 1 : 0;
            end
            if (underrun_clr) begin
                m_und = 1'b0;
                m_cnt = 16'h0;
            end else if (ev) begin
                m_und = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            if (push) m_q.push_back(s_data_i);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of both DUTs against the model.
    initial forever begin
        @(negedge clk);
        if (m_ok) begin
            chk("txd_zero",   {12'h0, txd_z}, {12'h0, m_txd[0]});
            chk("txd_repeat", {12'h0, txd_r}, {12'h0, m_txd[1]});
            chk("txiqsel",    {22'h0, sel_r, sel_z}, {22'h0, m_sel, m_sel});
            chk("fifo_level", {14'h0, lvl_r, lvl_z}, {14'h0, 5'(m_q.size()), 5'(m_q.size())});
            chk("s_ready",    {22'h0, rdy_r, rdy_z}, {22'h0, m_q.size() < 16, m_q.size() < 16});
            chk("underrun",   {22'h0, und_r, und_z}, {22'h0, m_und, m_und});
            chk("cnt_zero",   {8'h0, cnt_z}, {8'h0, m_cnt});
            chk("cnt_repeat", {8'h0, cnt_r}, {8'h0, m_cnt});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // 1: reset, two pairs streamed I,Q,I,Q
        step(2);
        chk("rst_txd", {12'h0, txd_z}, 24'h0);
        chk("rst_ready", {23'h0, rdy_z}, 24'h1);
        rst_n = 1'b1; en = 1'b1; s_valid_i = 1'b1; s_data_i = {12'h123, 12'h456};
        step(1);
        s_data_i = {12'h789, 12'hABC};
        step(1);
        s_valid_i = 1'b0;
        chk("t1_w0", {11'h0, sel_z, txd_z}, {11'h0, 1'b0, 12'h123});
        step(1);
        chk("t1_w1", {11'h0, sel_z, txd_z}, {11'h0, 1'b1, 12'h456});
        step(1);
        chk("t1_w2", {11'h0, sel_z, txd_z}, {11'h0, 1'b0, 12'h789});
        step(1);
        chk("t1_w3", {11'h0, sel_z, txd_z}, {11'h0, 1'b1, 12'hABC});
        // 2/3: starvation in both underrun modes
        step(1);
        chk("t2_zero_txd", {12'h0, txd_z}, 24'h0);
        chk("t3_rep_txd", {12'h0, txd_r}, 24'h789);
        chk("t2_und", {23'h0, und_z}, 24'h1);
        step(2);
        chk("t2_cnt2", {8'h0, cnt_z}, 24'h2);
        underrun_clr = 1'b1;
        step(2);
        chk("t2_clr_prio", {7'h0, und_z, cnt_z}, 24'h0);
        underrun_clr = 1'b0; en = 1'b0;
        step(2);
        chk("t2_idle", {7'h0, und_z, cnt_z}, 24'h0);
        chk("t2_idle_txd", {12'h0, txd_z}, 24'h0);
        s_valid_i = 1'b1; s_data_i = {12'h111, 12'h222};
        step(1);
        s_valid_i = 1'b0; en = 1'b1;
        step(2);
        chk("t3_w0", {12'h0, txd_r}, 24'h111);
        step(2);
        chk("t3_rep_i", {12'h0, txd_r}, 24'h111);
        step(1);
        chk("t3_rep_q", {12'h0, txd_r}, 24'h222);
        step(1);
        chk("t3_cnt", {8'h0, cnt_r}, 24'h2);
        en = 1'b0;
        step(2);
        underrun_clr = 1'b1;
        step(1);
        underrun_clr = 1'b0;
        // 4: fill to 16, 17th push dropped, then drain in order
        for (int i = 0; i < 17; i++) begin
            s_valid_i = 1'b1;
            s_data_i = {12'h100 + 12'(i), 12'h200 + 12'(i)};
            step(1);
        end
        s_valid_i = 1'b0;
        chk("t4_level", {19'h0, lvl_z}, 24'd16);
        chk("t4_ready", {23'h0, rdy_z}, 24'h0);
        en = 1'b1;
        step(2);
        chk("t4_first", {12'h0, txd_z}, 24'h100);
        step(31);
        chk("t4_last_q", {12'h0, txd_z}, 24'h20F);
        chk("t4_empty", {19'h0, lvl_z}, 24'h0);
        en = 1'b0;
        step(3);
        underrun_clr = 1'b1;
        step(1);
        underrun_clr = 1'b0;
        // 5: en drop and iq_swap during S_Q, then a swapped pair
        s_valid_i = 1'b1; s_data_i = {12'hAAA, 12'hBBB};
        step(1);
        s_data_i = {12'hCCC, 12'hDDD};
        step(1);
        s_valid_i = 1'b0; en = 1'b1;
        step(2);
        chk("t5_i", {12'h0, txd_z}, 24'hAAA);
        en = 1'b0; iq_swap = 1'b1;
        step(1);
        chk("t5_q_unswapped", {11'h0, sel_z, txd_z}, {11'h0, 1'b1, 12'hBBB});
        step(1);
        chk("t5_idle", {11'h0, sel_z, txd_z}, 24'h0);
        en = 1'b1;
        step(2);
        chk("t5_swap_first", {11'h0, sel_z, txd_z}, {11'h0, 1'b0, 12'hDDD});
        step(1);
        chk("t5_swap_second", {11'h0, sel_z, txd_z}, {11'h0, 1'b1, 12'hCCC});
        iq_swap = 1'b0; en = 1'b0;
        step(2);
        chk("t6_pre_cnt", {8'h0, cnt_z}, 24'h1);
        // 6: reset mid-pair with five pairs buffered
        for (int i = 0; i < 6; i++) begin
            s_valid_i = 1'b1;
            s_data_i = {12'h300 + 12'(i), 12'h400 + 12'(i)};
            step(1);
        end
        s_valid_i = 1'b0; en = 1'b1;
        step(2);
        chk("t6_level5", {19'h0, lvl_z}, 24'd5);
        chk("t6_mid_i", {11'h0, sel_z, txd_z}, {11'h0, 1'b0, 12'h300});
        rst_n = 1'b0;
        step(1);
        chk("t6_txd", {11'h0, sel_z, txd_z}, 24'h0);
        chk("t6_level", {19'h0, lvl_z}, 24'h0);
        chk("t6_cnt", {8'h0, cnt_z}, 24'h0);
        rst_n = 1'b1; en = 1'b0;
        step(3);
        chk("t6_ready", {23'h0, rdy_z}, 24'h1);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
